hs4_receiver: RTL
=================

Name: hs4_receiver

Overview:
- Synthesizable clocked receiver for the four-phase REQ/ACK data handshake that the buffer stage drives toward its consumer (REQ, DO, ACK).
- Synchronizes the incoming request, captures the data word, and runs the ACK side of the four-phase protocol.
- Buffers received words in a small FIFO with a valid/ready output port, and applies backpressure by withholding ACK while the FIFO is full.
- Checks that received words form an incrementing sequence and counts received words.

Parameters:
DW, 32, data width of data_i/out_data
DEPTH, 4, FIFO entries; must be a power of 2, at least 2
CW, 16, width of rx_count
SEQ_START, 0, first expected word for the sequence check

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req_i  input  1  four-phase request from the upstream buffer; asynchronous to clk
data_i  input  DW  data word; stable from before req_i rises until ack_o rises
ack_o  output  1  four-phase acknowledge, registered
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream consumer takes the head word
out_data  output  DW  FIFO head word, valid when out_valid=1
seq_err  output  1  sticky flag: a word differed from the expected value
err_data  output  DW  first offending word, held while seq_err=1
rx_count  output  CW  number of words accepted, saturating

Behaviour:
- Reset (async, rst_n=0):
  - ack_o=0, out_valid=0, seq_err=0, err_data=0, rx_count=0.
  - FIFO empty, expected value = SEQ_START, FSM in IDLE, synchronizer flops = 0.
  - ack_o goes low immediately, without waiting for a clock edge.
- req_i passes through a 2-flop synchronizer to give req_s. data_i is sampled unsynchronized, which is safe because the protocol holds it stable.
- FSM:
  - IDLE (ack_o=0): if req_s=1 and fifo_count<DEPTH, then push data_i, run the sequence check, increment rx_count, set ack_o=1, and go to WAIT_LO. Otherwise stay in IDLE.
  - WAIT_LO (ack_o=1): when req_s=0, set ack_o=0 and go to IDLE. No further capture happens in this state.
- Latency:
  - If edge k is the first edge sampling req_i=1, ack_o rises at edge k+2 and the word is in the FIFO after that edge (out_valid=1 at k+2 if the FIFO was empty).
  - If edge j is the first edge sampling req_i=0 in WAIT_LO, ack_o falls at edge j+2.
- Backpressure:
  - While the FIFO is full, IDLE holds ack_o=0 regardless of req_s.
  - Fullness is judged on the pre-edge count, so a pop on the same edge does not allow a push on that edge. The capture happens on the next edge.
- FIFO:
  - Push and pop may occur on the same edge when 0<count<DEPTH; count is unchanged and data order is preserved.
  - Pop happens iff out_valid and out_ready are both 1. out_ready is ignored while empty.
  - Pointers wrap modulo DEPTH.
- Sequence check:
  - On each capture, if data_i != expected and seq_err=0, then set seq_err=1 and err_data=data_i.
  - In all cases, expected becomes data_i+1 modulo 2^DW, so the check resyncs to the incoming stream.
  - 2^DW-1 followed by 0 is legal.
- rx_count increments by 1 per capture and saturates at 2^CW-1.
- Reset mid-handshake: if req_i is still high after reset release, it is treated as a new request and captured again. The upstream is expected to tolerate this.
- req_i glitches shorter than 2 clocks may be missed; this is legal because upstream holds req_i until ack_o rises.

Test Plan:
1. Single transfer: reset, then data_i=5 with req_i=1 held until ack_o rises, then req_i=0 → ack_o rises 2 edges after first sample of req_i=1; out_data=5 with out_valid=1; ack_o falls 2 edges after req_i=0 is sampled; rx_count=1; seq_err=0 (SEQ_START=5 for this test).
2. Stream 0..99 with out_ready=1 and the four-phase driver → 100 words popped in order 0..99; rx_count=100; seq_err=0.
3. Backpressure: out_ready=0, send 5 words → first 4 acked; 5th req_i held high with ack_o=0. Pulse out_ready for 1 cycle → 5th word acked on a later edge; FIFO pops 0,1,2,3,4 in order.
4. Sequence error: send 0,1,3,4 → seq_err=1 after the third capture; err_data=3; the word 4 raises no new error; seq_err stays 1.
5. Wrap: DW=8, SEQ_START=254, send 254,255,0 → seq_err=0. CW=2, send 5 words → rx_count saturates at 3.
6. Reset in WAIT_LO: assert rst_n=0 while ack_o=1 → ack_o=0 immediately, FIFO empty, counters 0. Release reset with req_i=1 → word re-captured; ack_o rises 2 edges later.

Source files
------------

// File: rtl/hs4_receiver.sv
// hs4_receiver: clocked ACK side of a four-phase REQ/ACK link. It feeds a small
// valid/ready FIFO and checks that received words form an incrementing sequence.
module hs4_receiver #(
    parameter int unsigned   DW        = 32,
    parameter int unsigned   DEPTH     = 4,
    parameter int unsigned   CW        = 16,
    parameter logic [DW-1:0] SEQ_START = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [DW-1:0] data_i,
    output logic          ack_o,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          seq_err,
    output logic [DW-1:0] err_data,
    output logic [CW-1:0] rx_count
);
    // state     | meaning
    // S_IDLE    | ack low; capture when synchronized req is high and FIFO has room
    // S_WAIT_LO | word captured, ack high until synchronized req returns low
    typedef enum logic {S_IDLE, S_WAIT_LO} state_t;

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic          req_meta_q, req_s_q;
    logic          ack_q, ack_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] exp_q, exp_d;
    logic          seq_err_q, seq_err_d;
    logic [DW-1:0] err_data_q, err_data_d;
    logic [CW-1:0] rx_count_q, rx_count_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push, pop, full;

    assign full = (count_q == FULL_CNT);
    assign pop  = (count_q != '0) && out_ready;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s_q && !full) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!req_s_q) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        exp_d      = exp_q;
        seq_err_d  = seq_err_q;
        err_data_d = err_data_q;
        rx_count_d = rx_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            // Resync to the incoming stream so one bad word reports one error.
            exp_d = data_i + 1'b1;
            if ((data_i != exp_q) && !seq_err_q) begin
                seq_err_d  = 1'b1;
                err_data_d = data_i;
            end
            if (rx_count_q != {CW{1'b1}}) begin
                rx_count_d = rx_count_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_q <= 1'b0;
            req_s_q    <= 1'b0;
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            exp_q      <= SEQ_START;
            seq_err_q  <= 1'b0;
            err_data_q <= '0;
            rx_count_q <= '0;
        end else begin
            req_meta_q <= req_i;
            req_s_q    <= req_meta_q;
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            exp_q      <= exp_d;
            seq_err_q  <= seq_err_d;
            err_data_q <= err_data_d;
            rx_count_q <= rx_count_d;
        end
    end

    // Storage needs no reset; out_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign ack_o     = ack_q;
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign seq_err   = seq_err_q;
    assign err_data  = err_data_q;
    assign rx_count  = rx_count_q;

endmodule
